// File: rtl/rs_15_11_pkg.sv
// Shared constants for the (15,11) Reed-Solomon code over GF(16).
// Used by the encoder and by the decoder stages (syndrome_4 onwards).
//   - symbol width, code length N, message length K, parity count
//   - primitive polynomial x^4+x+1 and generator coefficients G3..G0
//   - encoder state encoding
//   - gf16_mul: generic GF(16) multiply, meant for elaborating constants only
package rs_15_11_pkg;

    localparam int SYM_W = 4;
    localparam int N     = 15;
    localparam int K     = 11;
    localparam int NPAR  = N - K;

    // x^4 + x + 1
    localparam logic [4:0] PRIM_POLY = 5'b10011;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
    localparam logic [3:0] G3 = 4'd13;
    localparam logic [3:0] G2 = 4'd12;
    localparam logic [3:0] G1 = 4'd8;
    localparam logic [3:0] G0 = 4'd7;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } enc_state_t;

    // Shift-and-add multiply; only evaluated at elaboration time to derive
    // the XOR columns of the constant multipliers.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'd0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? PRIM_POLY[3:0] : 4'd0);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// Constant-coefficient GF(16) multiplier: prod = COEF * sym.
// Ports:
//   sym   in  4  multiplicand, polynomial basis
//   prod  out 4  product, polynomial basis
// Each input bit selects a precomputed column COEF*alpha^i, so the result is
// a pure XOR network with no run-time multiplication logic.
module gf16_const_mul
    import rs_15_11_pkg::*;
#(
    parameter logic [3:0] COEF = 4'd1
) (
    input  logic [3:0] sym,
    output logic [3:0] prod
);

    logic [3:0] term [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            localparam logic [3:0] COL = gf16_mul(COEF, 4'(1 << gi));
            assign term[gi] = sym[gi] ? COL : 4'd0;
        end
    endgenerate

    assign prod = term[0] ^ term[1] ^ term[2] ^ term[3];

endmodule

// File: rtl/rs_15_11_encoder.sv
// Systematic (15,11) Reed-Solomon encoder over GF(16).
// 11 message symbols are accepted through valid/ready and passed straight
// through; 4 parity symbols from an LFSR divider by g(x) follow. Highest
// degree symbol first, parity last (p3..p0).
// Ports:
//   CLK         in  1  clock, rising edge
//   RESET_N     in  1  asynchronous active-low reset
//   CLEAR       in  1  synchronous abort of the current block
//   IN_SERIAL   in  4  message symbol
//   IN_VALID    in  1  IN_SERIAL valid
//   IN_READY    out 1  high while accepting message symbols
//   OUT_SERIAL  out 4  codeword symbol (registered)
//   OUT_VALID   out 1  OUT_SERIAL valid
//   OUT_FIRST   out 1  codeword symbol 0
//   OUT_LAST    out 1  codeword symbol 14 (p0)
module rs_15_11_encoder
    import rs_15_11_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLEAR,
    input  logic [3:0] IN_SERIAL,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [3:0] OUT_SERIAL,
    output logic       OUT_VALID,
    output logic       OUT_FIRST,
    output logic       OUT_LAST
);

    localparam logic [15:0] GEN_COEFS    = {G3, G2, G1, G0};
    localparam logic [3:0]  MSG_LAST_CNT = 4'(K - 1);
    localparam logic [3:0]  PAR_LAST_CNT = 4'(NPAR - 1);

    enc_state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] r_reg  [NPAR];
    logic [3:0] r_next [NPAR];
    logic [3:0] out_serial_reg, out_serial_next;
    logic       out_valid_reg, out_valid_next;
    logic       out_first_reg, out_first_next;
    logic       out_last_reg, out_last_next;

    logic       accept;
    logic [3:0] fb;
    logic [3:0] fb_prod [NPAR];

    assign IN_READY = (state_reg == ST_DATA);
    assign accept   = IN_VALID & IN_READY;
    assign fb       = IN_SERIAL ^ r_reg[NPAR-1];

    // fb_prod[i] = fb * G_i
    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
            gf16_const_mul #(
                .COEF(GEN_COEFS[gi*4 +: 4])
            ) u_mul (
                .sym (fb),
                .prod(fb_prod[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        r_next          = r_reg;
        out_serial_next = out_serial_reg;
        out_valid_next  = 1'b0;
        out_first_next  = 1'b0;
        out_last_next   = 1'b0;

        if (CLEAR) begin
            // Abort wins over a simultaneous accept; that symbol is dropped.
            state_next = ST_DATA;
            cnt_next   = 4'd0;
            for (int i = 0; i < NPAR; i++) begin
                r_next[i] = 4'd0;
            end
        end else begin
            case (state_reg)
                ST_DATA: begin
                    if (accept) begin
                        r_next[0] = fb_prod[0];
                        for (int i = 1; i < NPAR; i++) begin
                            r_next[i] = r_reg[i-1] ^ fb_prod[i];
                        end
                        out_serial_next = IN_SERIAL;
                        out_valid_next  = 1'b1;
                        out_first_next  = (cnt_reg == 4'd0);
                        if (cnt_reg == MSG_LAST_CNT) begin
                            cnt_next   = 4'd0;
                            state_next = ST_PARITY;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    // Shifting zeros in leaves the LFSR cleared after the
                    // fourth parity symbol, ready for the next block.
                    out_serial_next = r_reg[NPAR-1];
                    out_valid_next  = 1'b1;
                    out_last_next   = (cnt_reg == PAR_LAST_CNT);
                    r_next[0]       = 4'd0;
                    for (int i = 1; i < NPAR; i++) begin
                        r_next[i] = r_reg[i-1];
                    end
                    if (cnt_reg == PAR_LAST_CNT) begin
                        cnt_next   = 4'd0;
                        state_next = ST_DATA;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = ST_DATA;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_DATA;
            cnt_reg        <= 4'd0;
            for (int i = 0; i < NPAR; i++) begin
                r_reg[i] <= 4'd0;
            end
            out_serial_reg <= 4'd0;
            out_valid_reg  <= 1'b0;
            out_first_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            for (int i = 0; i < NPAR; i++) begin
                r_reg[i] <= r_next[i];
            end
            out_serial_reg <= out_serial_next;
            out_valid_reg  <= out_valid_next;
            out_first_reg  <= out_first_next;
            out_last_reg   <= out_last_next;
        end
    end

    assign OUT_SERIAL = out_serial_reg;
    assign OUT_VALID  = out_valid_reg;
    assign OUT_FIRST  = out_first_reg;
    assign OUT_LAST   = out_last_reg;

endmodule

// File: doc/rs_15_11_encoder.md
# rs_15_11_encoder

Systematic (15,11) Reed-Solomon encoder over GF(16); produces the codewords that the decoder's syndrome_4 stage consumes. Accepts 11 serial 4-bit message symbols through a valid/ready handshake, passes them through, then appends 4 parity symbols computed by an LFSR divider using g(x) = (x+α)(x+α²)(x+α³)(x+α⁴). Symbol order matches the decoder input: highest-degree symbol first, parity last.

## Interface
- No parameters; field and code constants are fixed in the shared package.
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CLEAR  in  1  synchronous abort; discards the partial block and returns to DATA, count 0
- IN_SERIAL  in  4  message symbol, α-power polynomial basis
- IN_VALID  in  1  IN_SERIAL holds a valid symbol
- IN_READY  out  1  encoder accepts a symbol this cycle
- OUT_SERIAL  out  4  codeword symbol, registered
- OUT_VALID  out  1  OUT_SERIAL valid this cycle
- OUT_FIRST  out  1  marks codeword symbol 0 (message c14)
- OUT_LAST  out  1  marks codeword symbol 14 (parity p0)

## Operation
- Field: GF(16), primitive polynomial x⁴+x+1, so α=2, α⁴=3.
- Generator: g(x) = x⁴ + 13x³ + 12x² + 8x + 7, i.e. α¹³, α⁶, α³, α¹⁰.
- Two states with a 4-bit counter cnt:
  - DATA: IN_READY=1. On accept (IN_VALID & IN_READY):
    - fb = IN_SERIAL ^ r3
    - r3 ← r2 ^ fb·13; r2 ← r1 ^ fb·12; r1 ← r0 ^ fb·8; r0 ← fb·7
    - OUT_SERIAL ← IN_SERIAL; cnt increments.
    - The accept at cnt=10 sets cnt←0 and moves to PARITY.
  - PARITY: IN_READY=0. Every cycle:
    - OUT_SERIAL ← r3; shift r3←r2, r2←r1, r1←r0, r0←0.
    - At cnt=3, cnt←0 and move to DATA. The LFSR is then all zero with no explicit clear.
- Gaps in IN_VALID during DATA are allowed: no output and no LFSR change while no symbol is accepted.
- There is no output back-pressure; the downstream consumes every OUT_VALID cycle.
- CLEAR: state←DATA, cnt←0, LFSR←0, OUT_VALID←0. CLEAR has priority over a simultaneous accept; that symbol is dropped and not output.
- Constant multiplies are pure XOR networks.

## Timing
- Reset values (RESET_N low, asynchronous):
  - state=DATA, cnt=0, r0..r3=0
  - OUT_SERIAL=0, OUT_VALID=0, OUT_FIRST=0, OUT_LAST=0
  - IN_READY=1 as soon as reset deasserts.
- Latency is 1 cycle: a symbol accepted at edge k is on OUT_SERIAL with OUT_VALID=1 from edge k until edge k+1.
- The 11th accept is at edge k. Parity p3, p2, p1, p0 appear after edges k+1..k+4 on consecutive cycles. OUT_LAST=1 with p0.
- IN_READY is low during the 4 PARITY cycles. A new block's first symbol can be accepted at edge k+5, so continuous input gives back-to-back codewords with no output bubble.
- OUT_FIRST=1 with the output of the cnt=0 accept in DATA.
- RESET_N asserted mid-block aborts the block immediately; no partial parity is emitted.

## Structure
- Shared package rs_15_11_pkg holds:
  - symbol width (4), N=15, K=11, parity count 4
  - primitive polynomial, generator coefficients G3..G0 = 13, 12, 8, 7
  - state encoding
- rs_15_11_pkg is also used by syndrome_4 and the later decoder stages.
- One sub-module, gf16_const_mul: constant-coefficient GF(16) multiplier, coefficient as parameter. Instantiate it four times.

## Test plan
- All-zero message, 11 symbols, IN_VALID held high:
  - 15 outputs, all 0.
  - OUT_FIRST on output 0, OUT_LAST on output 14.
  - IN_READY low for exactly 4 cycles.
- Message 0,...,0,1 (c4=1):
  - parity p3..p0 = 13, 12, 8, 7.
- Message 0,...,0,2:
  - parity = 9, 11, 3, 14 (linearity check).
- Random messages, random IN_VALID gaps:
  - every codeword fed to syndrome_4 gives all four syndromes 0.
  - output symbols 0..10 equal the inputs.
  - back-to-back blocks with no gap produce no OUT_VALID bubble.
- Boundary cases:
  - CLEAR asserted after 6 accepts, together with a valid symbol: that symbol is dropped.
  - The next 11 symbols then encode exactly like a fresh block after reset.
  - Repeat with RESET_N pulsed low in the middle of PARITY: OUT_VALID drops at once, LFSR is zeroed, IN_READY=1 after release.
